// File: rtl/plic_target_arb.sv
// Per-target PLIC arbiter: two-stage priority tree plus claim/complete pulse generation.
// Latency: ip/ie/prio -> id_o 2 cycles, thold -> id_o 1 cycle, claim/complete pulses 1 cycle.
// Backpressure: none; strobes are single-cycle and always accepted, claims blank the output for 4 cycles.
module plic_target_arb #(
    parameter int SRC_NUM    = 32,
    parameter int PRIO_WIDTH = 3,
    parameter int ID_WIDTH   = $clog2(SRC_NUM)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [SRC_NUM-1:0]            ip_i,
    input  logic [SRC_NUM-1:0]            ie_i,
    input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i,
    input  logic [PRIO_WIDTH-1:0]         thold_i,
    input  logic                          claim_rd_i,
    input  logic                          comp_wr_i,
    input  logic [ID_WIDTH-1:0]           comp_id_i,
    output logic [ID_WIDTH-1:0]           id_o,
    output logic                          irq_o,
    output logic [SRC_NUM-1:0]            clam_o,
    output logic [SRC_NUM-1:0]            comp_o
);

    localparam int GRP  = 8;
    localparam int NGRP = SRC_NUM / GRP;

    typedef enum logic [0:0] {ARB, BLANK} state_t;

    // Stage 1: per-group winners
    logic [NGRP-1:0]                 g_vld;
    logic [NGRP-1:0][PRIO_WIDTH-1:0] g_prio;
    logic [NGRP-1:0][ID_WIDTH-1:0]   g_id;
    logic [NGRP-1:0]                 s1_vld;
    logic [NGRP-1:0][PRIO_WIDTH-1:0] s1_prio;
    logic [NGRP-1:0][ID_WIDTH-1:0]   s1_id;

    // Stage 2: global winner, already qualified by threshold
    logic                  b_vld;
    logic [PRIO_WIDTH-1:0] b_prio;
    logic [ID_WIDTH-1:0]   b_id;
    logic [ID_WIDTH-1:0]   s2_id;

    state_t               state, state_nxt;
    logic [2:0]           cnt, cnt_nxt;
    logic [SRC_NUM-1:0]   clam_nxt, comp_nxt;
    logic                 claim_go;

    // Ascending scan with strict '>' keeps the lowest ID on equal priority.
    always_comb begin
        g_vld  = '0;
        g_prio = '0;
        g_id   = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < GRP; i++) begin
                if (ip_i[g*GRP+i] && ie_i[g*GRP+i] && (g*GRP+i != 0) &&
                    (prio_i[(g*GRP+i)*PRIO_WIDTH +: PRIO_WIDTH] != '0) &&
                    (!g_vld[g] || (prio_i[(g*GRP+i)*PRIO_WIDTH +: PRIO_WIDTH] > g_prio[g]))) begin
                    g_vld[g]  = 1'b1;
                    g_prio[g] = prio_i[(g*GRP+i)*PRIO_WIDTH +: PRIO_WIDTH];
                    g_id[g]   = ID_WIDTH'(g*GRP+i);
                end
            end
        end
    end

    always_comb begin
        b_vld  = 1'b0;
        b_prio = '0;
        b_id   = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (s1_vld[g] && (!b_vld || (s1_prio[g] > b_prio))) begin
                b_vld  = 1'b1;
                b_prio = s1_prio[g];
                b_id   = s1_id[g];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld  <= '0;
            s1_prio <= '0;
            s1_id   <= '0;
            s2_id   <= '0;
        end else begin
            s1_vld  <= g_vld;
            s1_prio <= g_prio;
            s1_id   <= g_id;
            s2_id   <= (b_vld && (b_prio > thold_i)) ? b_id : '0;
        end
    end

    assign id_o  = (state == ARB) ? s2_id : '0;
    assign irq_o = (id_o != '0);

    assign claim_go = (state == ARB) && claim_rd_i && (id_o != '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clam_nxt  = '0;
        comp_nxt  = '0;
        case (state)
            ARB: begin
                if (claim_go) begin
                    state_nxt = BLANK;
                    cnt_nxt   = 3'd4;
                end
            end
            BLANK: begin
                // Last blank cycle is the one where the counter reads 1.
                cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    state_nxt = ARB;
                    cnt_nxt   = 3'd0;
                end
            end
            default: begin
                state_nxt = ARB;
                cnt_nxt   = 3'd0;
            end
        endcase
        for (int n = 0; n < SRC_NUM; n++) begin
            clam_nxt[n] = claim_go && (id_o == ID_WIDTH'(n));
            comp_nxt[n] = comp_wr_i && (n != 0) && (comp_id_i == ID_WIDTH'(n)) && ie_i[n];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ARB;
            cnt    <= 3'd0;
            clam_o <= '0;
            comp_o <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            clam_o <= clam_nxt;
            comp_o <= comp_nxt;
        end
    end

endmodule

// File: tb/tb_plic_target_arb.sv
// Directed bench for plic_target_arb: arbitration, threshold, claim blanking, complete and reset.
module tb_plic_target_arb;

    localparam int SRC_NUM = 32;
    localparam int PW      = 3;
    localparam int IW      = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [SRC_NUM-1:0]      ip, ie;
    logic [SRC_NUM*PW-1:0]   prio;
    logic [PW-1:0]           thold;
    logic                    claim_rd, comp_wr;
    logic [IW-1:0]           comp_id;
    logic [IW-1:0]           id_o;
    logic                    irq_o;
    logic [SRC_NUM-1:0]      clam_o, comp_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    plic_target_arb #(.SRC_NUM(SRC_NUM), .PRIO_WIDTH(PW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .ip_i       (ip),
        .ie_i       (ie),
        .prio_i     (prio),
        .thold_i    (thold),
        .claim_rd_i (claim_rd),
        .comp_wr_i  (comp_wr),
        .comp_id_i  (comp_id),
        .id_o       (id_o),
        .irq_o      (irq_o),
        .clam_o     (clam_o),
        .comp_o     (comp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_prio(input int n, input int p);
        prio[n*PW +: PW] = PW'(p);
    endtask

    initial begin
        rst_n    = 1'b0;
        ip       = '0;
        ie       = '1;
        prio     = '0;
        thold    = '0;
        claim_rd = 1'b0;
        comp_wr  = 1'b0;
        comp_id  = '0;
        #23;
        chk("rst_id",   32'(id_o),  32'd0);
        chk("rst_irq",  32'(irq_o), 32'd0);
        chk("rst_clam", clam_o,     32'd0);
        chk("rst_comp", comp_o,     32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single source, threshold below and equal to its priority
        set_prio(5, 3);
        thold = 3'd1;
        ip[5] = 1'b1;
        tick();
        chk("lat1_id", 32'(id_o), 32'd0);
        tick();
        chk("lat2_id",  32'(id_o),  32'd5);
        chk("lat2_irq", 32'(irq_o), 32'd1);
        thold = 3'd3;
        tick();
        chk("thold_eq_id",  32'(id_o),  32'd0);
        chk("thold_eq_irq", 32'(irq_o), 32'd0);
        thold = 3'd1;
        tick();
        chk("thold_back_id", 32'(id_o), 32'd5);

        // Tie on priority: lowest ID wins, then priority raise takes over
        ip = '0;
        ip[9] = 1'b1; ip[4] = 1'b1; ip[20] = 1'b1;
        set_prio(9, 2); set_prio(4, 2); set_prio(20, 2);
        tick();
        tick();
        chk("tie_id", 32'(id_o), 32'd4);
        set_prio(20, 7);
        tick();
        chk("raise_1cyc_id", 32'(id_o), 32'd4);
        tick();
        chk("raise_2cyc_id", 32'(id_o), 32'd20);

        // Claim source 5 with blanking and an ignored claim inside the blank window
        ip = '0;
        ip[5] = 1'b1;
        tick();
        tick();
        chk("pre_claim_id", 32'(id_o), 32'd5);
        claim_rd = 1'b1;
        tick();
        chk("claim_c1_clam", clam_o,      32'h20);
        chk("claim_c1_id",   32'(id_o),   32'd0);
        chk("claim_c1_irq",  32'(irq_o),  32'd0);
        claim_rd = 1'b0;
        tick();
        chk("claim_c2_clam", clam_o,    32'd0);
        chk("claim_c2_id",   32'(id_o), 32'd0);
        claim_rd = 1'b1;
        tick();
        chk("claim_c3_clam", clam_o,    32'd0);
        chk("claim_c3_id",   32'(id_o), 32'd0);
        claim_rd = 1'b0;
        tick();
        chk("claim_c4_id",  32'(id_o),  32'd0);
        chk("claim_c4_irq", 32'(irq_o), 32'd0);
        tick();
        chk("claim_c5_id",  32'(id_o),  32'd5);
        chk("claim_c5_irq", 32'(irq_o), 32'd1);

        // Complete: valid, reserved ID 0, disabled source
        comp_wr = 1'b1;
        comp_id = 5'd5;
        tick();
        chk("comp5_pulse", comp_o, 32'h20);
        comp_wr = 1'b0;
        tick();
        chk("comp5_end", comp_o, 32'd0);
        comp_wr = 1'b1;
        comp_id = 5'd0;
        tick();
        chk("comp0_none", comp_o, 32'd0);
        comp_id = 5'd5;
        ie[5]   = 1'b0;
        tick();
        chk("comp_dis_none", comp_o, 32'd0);
        comp_wr = 1'b0;
        ie[5]   = 1'b1;

        // Simultaneous claim and complete
        ip = '0;
        ip[7] = 1'b1;
        set_prio(7, 3);
        tick();
        tick();
        chk("pre_both_id", 32'(id_o), 32'd7);
        claim_rd = 1'b1;
        comp_wr  = 1'b1;
        comp_id  = 5'd3;
        tick();
        chk("both_clam", clam_o, 32'h80);
        chk("both_comp", comp_o, 32'h8);
        claim_rd = 1'b0;
        comp_wr  = 1'b0;
        tick();
        chk("both_clam_end", clam_o, 32'd0);
        chk("both_comp_end", comp_o, 32'd0);
        tick();
        tick();
        tick();
        chk("both_resume_id", 32'(id_o), 32'd7);

        // Reset during blanking, one cycle after claim
        claim_rd = 1'b1;
        tick();
        chk("rst_pre_clam", clam_o, 32'h80);
        claim_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_clam", clam_o,     32'd0);
        chk("arst_id",   32'(id_o),  32'd0);
        chk("arst_irq",  32'(irq_o), 32'd0);
        chk("arst_comp", comp_o,     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_lat1_id", 32'(id_o), 32'd0);
        tick();
        chk("post_rst_id",  32'(id_o),  32'd7);
        chk("post_rst_irq", 32'(irq_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
